// File: rtl/pwm_capture_spi_reader.sv
// Fetches capture words from the PWM capture core and serves them to an SPI master (mode 0, MSB first).
// Build option: define SPI_STATUS_HDR_EN to prefix every SPI frame with an 8-bit status byte.
module pwm_capture_spi_reader #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cap_int_i,
    input  logic [DATA_W-1:0] cap_data_i,
    output logic              cap_oe_o,
    output logic              int_clr_o,
    output logic              data_rdy_o,
    input  logic              spi_sclk_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o
);

`ifdef SPI_STATUS_HDR_EN
    localparam int HDR_W = 8;
`else
    localparam int HDR_W = 0;
`endif
    localparam int FRAME_W = DATA_W + HDR_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OE    = 3'd1,
        ST_LATCH = 3'd2,
        ST_READY = 3'd3,
        ST_SHIFT = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      word_q, word_d;
    logic [FRAME_W-1:0]     shreg_q, shreg_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   cap_oe_q, cap_oe_d;
    logic                   int_clr_q, int_clr_d;
    logic                   data_rdy_q, data_rdy_d;
    logic                   miso_q, miso_d;

    logic                   sclk_s;
    logic                   cs_n_s;
    logic                   sclk_rise_s;
    logic                   sclk_fall_s;
    logic                   cs_fall_s;
    logic                   cs_rise_s;
    logic                   unused_mosi_s;
    logic [DATA_W-1:0]      body_s;
    logic [FRAME_W-1:0]     load_s;

    assign sclk_s        = sclk_sync_q[SYNC_STAGES-1];
    assign cs_n_s        = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise_s   = sclk_s & ~sclk_prev_q;
    assign sclk_fall_s   = ~sclk_s & sclk_prev_q;
    assign cs_fall_s     = ~cs_n_s & cs_prev_q;
    assign cs_rise_s     = cs_n_s & ~cs_prev_q;
    // MOSI is synchronised like the other pins but a read-only slave has no use for it.
    assign unused_mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Pin synchronisers plus one history flop each for edge detection; CS idles high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= {SYNC_STAGES{1'b0}};
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_n_s;
        end
    end

    // Frame contents at CS fall: the word only when one is ready, otherwise zeros.
    always_comb begin
        if (state_q == ST_READY) begin
            body_s = word_q;
        end else begin
            body_s = {DATA_W{1'b0}};
        end
`ifdef SPI_STATUS_HDR_EN
        load_s = {data_rdy_q, cap_int_i, 6'b000000, body_s};
`else
        load_s = body_s;
`endif
    end

    // Next-state logic: shifter and bit counter run for every frame, the FSM decides what is served.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;

        if (cs_fall_s) begin
            shreg_d   = load_s;
            bit_cnt_d = {CNT_W{1'b0}};
        end else if (cs_n_s) begin
            shreg_d   = {FRAME_W{1'b0}};
            bit_cnt_d = {CNT_W{1'b0}};
        end else begin
            if (sclk_fall_s) begin
                shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
            end else begin
                shreg_d = shreg_q;
            end
            if (sclk_rise_s && (bit_cnt_q != CNT_FULL)) begin
                bit_cnt_d = bit_cnt_q + CNT_ONE;
            end else begin
                bit_cnt_d = bit_cnt_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (cap_int_i && cs_n_s) begin
                    state_d = ST_OE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OE: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                word_d  = cap_data_i;
                state_d = ST_READY;
            end
            ST_READY: begin
                if (cs_fall_s) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_s) begin
                    if (bit_cnt_q == CNT_FULL) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_READY;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state they belong to.
        cap_oe_d   = (state_d == ST_OE) || (state_d == ST_LATCH);
        int_clr_d  = (state_d == ST_LATCH);
        data_rdy_d = (state_d == ST_READY) || (state_d == ST_SHIFT);
        miso_d     = ~cs_n_s & shreg_d[FRAME_W-1];
    end

    // State and datapath registers; reset discards any latched word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            word_q     <= {DATA_W{1'b0}};
            shreg_q    <= {FRAME_W{1'b0}};
            bit_cnt_q  <= {CNT_W{1'b0}};
            cap_oe_q   <= 1'b0;
            int_clr_q  <= 1'b0;
            data_rdy_q <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            cap_oe_q   <= cap_oe_d;
            int_clr_q  <= int_clr_d;
            data_rdy_q <= data_rdy_d;
            miso_q     <= miso_d;
        end
    end

    assign cap_oe_o   = cap_oe_q;
    assign int_clr_o  = int_clr_q;
    assign data_rdy_o = data_rdy_q;
    assign spi_miso_o = miso_q;

endmodule

// File: tb/tb_pwm_capture_spi_reader.sv
// Self-checking bench for pwm_capture_spi_reader: models the capture core and an SPI mode-0 master.
// Frame length and header expectations follow SPI_STATUS_HDR_EN when it is defined.
module tb_pwm_capture_spi_reader;

`ifdef SPI_STATUS_HDR_EN
    localparam int HDR_W = 8;
`else
    localparam int HDR_W = 0;
`endif
    localparam int FRAME_W = 32 + HDR_W;
    localparam int HP      = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_int;
    logic [31:0] core_data = 32'h0;
    logic        set_req = 1'b0;
    logic [31:0] cap_data;
    logic        cap_oe, int_clr, data_rdy;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;

    int n_cmp  = 0;
    int n_fail = 0;
    int int_clr_cycles = 0;
    int cap_oe_cycles  = 0;

    logic [31:0] exp_words[$];
    logic [63:0] exp_frames[$];

    always #5 clk = ~clk;

    pwm_capture_spi_reader #(.DATA_W(32), .SYNC_STAGES(2)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cap_int_i  (core_int),
        .cap_data_i (cap_data),
        .cap_oe_o   (cap_oe),
        .int_clr_o  (int_clr),
        .data_rdy_o (data_rdy),
        .spi_sclk_i (spi_sclk),
        .spi_cs_n_i (spi_cs_n),
        .spi_mosi_i (spi_mosi),
        .spi_miso_o (spi_miso)
    );

    // Capture core model: level interrupt held until int_clr, data visible only while enabled.
    assign cap_data = cap_oe ? core_data : 32'h0;
    always @(posedge clk) begin
        if (rst)          core_int <= 1'b0;
        else if (set_req) core_int <= 1'b1;
        else if (int_clr) core_int <= 1'b0;
    end

    always @(posedge clk) begin
        if (int_clr) int_clr_cycles <= int_clr_cycles + 1;
        if (cap_oe)  cap_oe_cycles  <= cap_oe_cycles + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    function automatic logic [63:0] make_frame(input logic rdy, input logic irq, input logic [31:0] w);
        logic [7:0] hdr;
        hdr = {rdy, irq, 6'b000000};
        if (HDR_W == 8) make_frame = {24'h0, hdr, w};
        else            make_frame = {32'h0, w};
    endfunction

    task automatic raise_capture(input logic [31:0] w);
        core_data = w;
        set_req   = 1'b1;
        @(negedge clk);
        set_req   = 1'b0;
        exp_words.push_back(w);
    endtask

    task automatic wait_rdy(output bit ok);
        int n;
        n = 0;
        while (data_rdy !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        ok = (data_rdy === 1'b1);
    endtask

    task automatic spi_xfer(input int nbits, output logic [63:0] rx);
        rx = 64'h0;
        spi_cs_n = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx = {rx[62:0], spi_miso};
            spi_mosi = 1'($urandom_range(0, 1));
            spi_sclk = 1'b1;
            repeat (HP) @(negedge clk);
            spi_sclk = 1'b0;
            repeat (HP) @(negedge clk);
        end
        spi_cs_n = 1'b1;
        repeat (HP) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp += 4;
        if (cap_oe !== 1'b0)   begin n_fail++; $display("FAIL reset_cap_oe: got %b, required 0", cap_oe); end
        if (int_clr !== 1'b0)  begin n_fail++; $display("FAIL reset_int_clr: got %b, required 0", int_clr); end
        if (data_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_data_rdy: got %b, required 0", data_rdy); end
        if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b, required 0", spi_miso); end
    endtask

    task automatic test_capture_read;
        int clr0, oe0;
        bit ok;
        logic [63:0] rx, exp;
        clr0 = int_clr_cycles;
        oe0  = cap_oe_cycles;
        raise_capture(32'hDEADBEEF);
        wait_rdy(ok);
        repeat (4) @(negedge clk);
        n_cmp += 4;
        if (!ok) begin n_fail++; $display("FAIL cap_rdy: data_rdy=%b, required 1", data_rdy); end
        if (int_clr_cycles - clr0 != 1) begin n_fail++; $display("FAIL cap_int_clr: %0d cycles, required 1", int_clr_cycles - clr0); end
        if (cap_oe_cycles - oe0 != 2)   begin n_fail++; $display("FAIL cap_oe_len: %0d cycles, required 2", cap_oe_cycles - oe0); end
        if (core_int !== 1'b0)          begin n_fail++; $display("FAIL cap_cleared: cap_int=%b, required 0", core_int); end
        exp_frames.push_back(make_frame(1'b1, core_int, exp_words.pop_front()));
        spi_xfer(FRAME_W, rx);
        exp = exp_frames.pop_front();
        n_cmp += 2;
        if (rx !== exp)        begin n_fail++; $display("FAIL read1_data: got %h, required %h", rx, exp); end
        if (data_rdy !== 1'b0) begin n_fail++; $display("FAIL read1_rdy_clear: got %b, required 0", data_rdy); end
    endtask

    task automatic test_aborted_read;
        bit ok;
        logic [63:0] rx, exp;
        raise_capture(32'hDEADBEEF);
        wait_rdy(ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL abort_rdy: data_rdy=%b, required 1", data_rdy); end
        exp = make_frame(1'b1, core_int, exp_words[0]) >> (FRAME_W - 16);
        spi_xfer(16, rx);
        n_cmp += 2;
        if (rx !== exp)        begin n_fail++; $display("FAIL abort_bits: got %h, required %h", rx, exp); end
        if (data_rdy !== 1'b1) begin n_fail++; $display("FAIL abort_rdy_kept: got %b, required 1", data_rdy); end
        exp_frames.push_back(make_frame(1'b1, core_int, exp_words.pop_front()));
        spi_xfer(FRAME_W, rx);
        exp = exp_frames.pop_front();
        n_cmp += 2;
        if (rx !== exp)        begin n_fail++; $display("FAIL reread_data: got %h, required %h", rx, exp); end
        if (data_rdy !== 1'b0) begin n_fail++; $display("FAIL reread_rdy_clear: got %b, required 0", data_rdy); end
    endtask

    task automatic test_pending_event;
        int clr0;
        bit ok;
        logic [63:0] rx, exp;
        raise_capture(32'hDEADBEEF);
        wait_rdy(ok);
        repeat (4) @(negedge clk);
        clr0 = int_clr_cycles;
        raise_capture(32'h00000001);
        repeat (20) @(negedge clk);
        n_cmp += 3;
        if (!ok) begin n_fail++; $display("FAIL pend_rdy: data_rdy=%b, required 1", data_rdy); end
        if (int_clr_cycles != clr0) begin n_fail++; $display("FAIL pend_no_clr: %0d pulses, required 0", int_clr_cycles - clr0); end
        if (core_int !== 1'b1)      begin n_fail++; $display("FAIL pend_held: cap_int=%b, required 1", core_int); end
        exp_frames.push_back(make_frame(1'b1, core_int, exp_words.pop_front()));
        spi_xfer(FRAME_W, rx);
        exp = exp_frames.pop_front();
        n_cmp++;
        if (rx !== exp) begin n_fail++; $display("FAIL pend_first: got %h, required %h", rx, exp); end
        wait_rdy(ok);
        repeat (4) @(negedge clk);
        n_cmp += 2;
        if (!ok) begin n_fail++; $display("FAIL pend_second_rdy: data_rdy=%b, required 1", data_rdy); end
        if (int_clr_cycles - clr0 != 1) begin n_fail++; $display("FAIL pend_second_clr: %0d pulses, required 1", int_clr_cycles - clr0); end
        exp_frames.push_back(make_frame(1'b1, core_int, exp_words.pop_front()));
        spi_xfer(FRAME_W, rx);
        exp = exp_frames.pop_front();
        n_cmp++;
        if (rx !== exp) begin n_fail++; $display("FAIL pend_second: got %h, required %h", rx, exp); end
    endtask

    task automatic test_empty_read;
        int clr0;
        logic [63:0] rx, exp;
        clr0 = int_clr_cycles;
        exp_frames.push_back(make_frame(1'b0, core_int, 32'h0));
        spi_xfer(FRAME_W, rx);
        exp = exp_frames.pop_front();
        n_cmp += 3;
        if (rx !== exp)               begin n_fail++; $display("FAIL empty_data: got %h, required %h", rx, exp); end
        if (int_clr_cycles != clr0)   begin n_fail++; $display("FAIL empty_no_clr: %0d pulses, required 0", int_clr_cycles - clr0); end
        if (data_rdy !== 1'b0)        begin n_fail++; $display("FAIL empty_rdy: got %b, required 0", data_rdy); end
    endtask

    task automatic test_extra_clocks;
        bit ok;
        logic [63:0] rx, exp;
        raise_capture(32'hA5C3_0F96);
        wait_rdy(ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL extra_rdy: data_rdy=%b, required 1", data_rdy); end
        exp_frames.push_back(make_frame(1'b1, core_int, exp_words.pop_front()) << 4);
        spi_xfer(FRAME_W + 4, rx);
        exp = exp_frames.pop_front();
        n_cmp += 2;
        if (rx !== exp)        begin n_fail++; $display("FAIL extra_data: got %h, required %h", rx, exp); end
        if (data_rdy !== 1'b0) begin n_fail++; $display("FAIL extra_rdy_clear: got %b, required 0", data_rdy); end
    endtask

    task automatic test_reset_midframe;
        bit ok;
        logic [63:0] rx, exp;
        raise_capture(32'h5A5A_1234);
        wait_rdy(ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL midrst_rdy: data_rdy=%b, required 1", data_rdy); end
        spi_cs_n = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            spi_sclk = 1'b1;
            repeat (HP) @(negedge clk);
            spi_sclk = 1'b0;
            repeat (HP) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(exp_words.pop_front());
        n_cmp += 3;
        if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL midrst_miso: got %b, required 0", spi_miso); end
        if (data_rdy !== 1'b0) begin n_fail++; $display("FAIL midrst_rdy_clear: got %b, required 0", data_rdy); end
        if (cap_oe !== 1'b0)   begin n_fail++; $display("FAIL midrst_cap_oe: got %b, required 0", cap_oe); end
        spi_cs_n = 1'b1;
        repeat (HP) @(negedge clk);
        raise_capture(32'h0F0F_C001);
        wait_rdy(ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL fresh_rdy: data_rdy=%b, required 1", data_rdy); end
        exp_frames.push_back(make_frame(1'b1, core_int, exp_words.pop_front()));
        spi_xfer(FRAME_W, rx);
        exp = exp_frames.pop_front();
        n_cmp++;
        if (rx !== exp) begin n_fail++; $display("FAIL fresh_data: got %h, required %h", rx, exp); end
    endtask

    task automatic test_fixed_frame;
        bit ok;
        logic [63:0] rx, exp;
`ifdef SPI_STATUS_HDR_EN
        exp = 64'h00000080_12345678;
`else
        exp = 64'h00000000_12345678;
`endif
        raise_capture(32'h12345678);
        wait_rdy(ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL fixed_rdy: data_rdy=%b, required 1", data_rdy); end
        void'(exp_words.pop_front());
        spi_xfer(FRAME_W, rx);
        n_cmp++;
        if (rx !== exp) begin n_fail++; $display("FAIL fixed_frame: got %h, required %h", rx, exp); end
    endtask

    initial begin
        test_reset();
        test_capture_read();
        test_aborted_read();
        test_pending_event();
        test_empty_read();
        test_extra_clocks();
        test_reset_midframe();
        test_fixed_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
